// File: rtl/fp32_to_int_converter.sv
// Purpose : FP32 -> signed INT_WIDTH converter, value = x * 2^i_scale, round-to-nearest-even, saturating.
// Latency : 2 cycles (S1 decode register, S2 shift/round/saturate output register), 1 result per cycle.
// Backpressure: valid/ready; a stage advances when the next one is empty or draining, o_ready = ~s1_valid | s2 loads.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_valid/o_ready, i_data       FP32 operand stream in
//   i_scale                       signed power-of-two scale applied before conversion
//   o_valid/i_ready, o_data       signed integer result stream out
//   o_sat, o_invalid, o_inexact   per-result flags (clamped, NaN operand, rounding lost bits)
module fp32_to_int_converter #(
  parameter int INT_WIDTH   = 32,
  parameter int SCALE_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [31:0]            i_data,
  input  logic [SCALE_WIDTH-1:0] i_scale,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [INT_WIDTH-1:0]   o_data,
  output logic                   o_sat,
  output logic                   o_invalid,
  output logic                   o_inexact
);

  // Unbiased, scaled exponent range is about -159..+160, so 10 signed bits suffice.
  localparam int EW = 10;

  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  localparam logic signed [EW-1:0] C_BIAS = 10'sd127;
  localparam logic signed [EW-1:0] C_23   = 10'sd23;
  localparam logic signed [EW-1:0] C_8    = 10'sd8;
  localparam logic signed [EW-1:0] C_25   = 10'sd25;

  // ---------------- handshake ----------------
  logic w_s1_load;
  logic w_s2_load;
  logic r_s1_valid;
  logic r_s2_valid;

  assign w_s2_load = ~r_s2_valid | i_ready;
  assign w_s1_load = ~r_s1_valid | w_s2_load;
  assign o_ready   = w_s1_load;
  assign o_valid   = r_s2_valid;

  // ---------------- S1 decode ----------------
  logic                 w_sign;
  logic [7:0]           w_bexp;
  logic [22:0]          w_mant;
  logic [1:0]           w_cls;
  logic signed [EW-1:0] w_scale_ext;
  logic signed [EW-1:0] w_exp;

  assign w_sign      = i_data[31];
  assign w_bexp      = i_data[30:23];
  assign w_mant      = i_data[22:0];
  assign w_scale_ext = {{(EW-SCALE_WIDTH){i_scale[SCALE_WIDTH-1]}}, i_scale};
  assign w_exp       = $signed({2'b00, w_bexp}) - C_BIAS + w_scale_ext;

  always_comb begin
    w_cls = CLS_NORM;
    if (w_bexp == 8'hFF) begin
      w_cls = (w_mant != 23'd0) ? CLS_NAN : CLS_INF;
    end else if (w_bexp == 8'h00) begin
      w_cls = CLS_ZERO;
    end
  end

  logic                 r_s1_sign;
  logic [1:0]           r_s1_cls;
  logic signed [EW-1:0] r_s1_exp;
  logic [23:0]          r_s1_sig;
  logic                 r_s1_zinex;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_cls   <= CLS_ZERO;
      r_s1_exp   <= '0;
      r_s1_sig   <= '0;
      r_s1_zinex <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_sign  <= w_sign;
        r_s1_cls   <= w_cls;
        r_s1_exp   <= w_exp;
        r_s1_sig   <= {1'b1, w_mant};
        // Denormals flush to zero; any dropped mantissa bit makes that inexact.
        r_s1_zinex <= (w_mant != 23'd0);
      end
    end
  end

  // ---------------- S2 shift / round / saturate ----------------
  logic signed [EW-1:0] w_lsh;
  logic signed [EW-1:0] w_rsh;
  logic [4:0]           w_rsh_c;
  logic [47:0]          w_ext;
  logic [63:0]          w_mag;
  logic [63:0]          w_mag_rnd;
  logic [63:0]          w_limit;
  logic                 w_g;
  logic                 w_st;
  logic                 w_big;
  logic                 w_ovf;
  logic [INT_WIDTH-1:0] w_mag_n;
  logic [INT_WIDTH-1:0] w_max_pos;
  logic [INT_WIDTH-1:0] w_max_neg;
  logic [INT_WIDTH-1:0] w_res_data;
  logic                 w_res_sat;
  logic                 w_res_inv;
  logic                 w_res_inex;

  assign w_lsh     = r_s1_exp - C_23;
  assign w_rsh     = C_23 - r_s1_exp;
  assign w_max_pos = {1'b0, {(INT_WIDTH-1){1'b1}}};
  assign w_max_neg = {1'b1, {(INT_WIDTH-1){1'b0}}};

  always_comb begin
    w_mag   = '0;
    w_g     = 1'b0;
    w_st    = 1'b0;
    w_big   = 1'b0;
    w_rsh_c = '0;
    w_ext   = '0;
    if (r_s1_exp >= C_23) begin
      // sig >= 2^23, so a left shift beyond 8 exceeds 2^32 and always overflows;
      // only shifts 0..8 need the actual magnitude.
      w_big = (w_lsh > C_8);
      w_mag = {40'd0, r_s1_sig} << w_lsh[3:0];
    end else begin
      // Beyond 25 every result is mag=0, g=0, st=1, so the shift saturates at 25.
      w_rsh_c = (w_rsh > C_25) ? 5'd25 : w_rsh[4:0];
      w_ext   = {r_s1_sig, 24'd0} >> w_rsh_c;
      w_mag   = {40'd0, w_ext[47:24]};
      w_g     = w_ext[23];
      w_st    = |w_ext[22:0];
    end
  end

  assign w_mag_rnd = w_mag + {63'd0, w_g & (w_st | w_mag[0])};
  assign w_limit   = r_s1_sign ? (64'd1 << (INT_WIDTH-1)) : ((64'd1 << (INT_WIDTH-1)) - 64'd1);
  assign w_ovf     = w_big | (w_mag_rnd > w_limit);
  assign w_mag_n   = w_mag_rnd[INT_WIDTH-1:0];

  always_comb begin
    w_res_data = '0;
    w_res_sat  = 1'b0;
    w_res_inv  = 1'b0;
    w_res_inex = 1'b0;
    case (r_s1_cls)
      CLS_NAN: begin
        w_res_inv = 1'b1;
      end
      CLS_INF: begin
        w_res_data = r_s1_sign ? w_max_neg : w_max_pos;
        w_res_sat  = 1'b1;
      end
      CLS_ZERO: begin
        w_res_inex = r_s1_zinex;
      end
      default: begin
        if (w_ovf) begin
          w_res_data = r_s1_sign ? w_max_neg : w_max_pos;
          w_res_sat  = 1'b1;
        end else begin
          // -0 naturally becomes 0; -2^(W-1) wraps onto itself.
          w_res_data = r_s1_sign ? -w_mag_n : w_mag_n;
          w_res_inex = w_g | w_st;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      o_data     <= '0;
      o_sat      <= 1'b0;
      o_invalid  <= 1'b0;
      o_inexact  <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        o_data    <= w_res_data;
        o_sat     <= w_res_sat;
        o_invalid <= w_res_inv;
        o_inexact <= w_res_inex;
      end
    end
  end

endmodule
